// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle RV32I control FSM.
//   - RV32I major opcode constants
//   - state_t   : FSM state encoding
//   - opclass_t : opcode class latched in DECODE
//   - ALUOp / ALUSrcA / PCSrc / WBSel encodings
//   - ctrl_t    : bundle of all datapath control outputs
//   - decode_opclass() : opcode -> class, OcNone for unknown opcodes
package ctrl_pkg;

    localparam logic [6:0] OpcR      = 7'b0110011;
    localparam logic [6:0] OpcImm    = 7'b0010011;
    localparam logic [6:0] OpcLoad   = 7'b0000011;
    localparam logic [6:0] OpcStore  = 7'b0100011;
    localparam logic [6:0] OpcBranch = 7'b1100011;
    localparam logic [6:0] OpcJal    = 7'b1101111;
    localparam logic [6:0] OpcJalr   = 7'b1100111;
    localparam logic [6:0] OpcLui    = 7'b0110111;
    localparam logic [6:0] OpcAuipc  = 7'b0010111;

    typedef enum logic [2:0] {
        StFetch,
        StDecode,
        StExec,
        StMem,
        StWb,
        StTrap
    } state_t;

    typedef enum logic [3:0] {
        OcNone,
        OcR,
        OcImm,
        OcLoad,
        OcStore,
        OcBranch,
        OcJal,
        OcJalr,
        OcLui,
        OcAuipc
    } opclass_t;

    localparam logic [1:0] AluOpAdd    = 2'b00;
    localparam logic [1:0] AluOpBranch = 2'b01;
    localparam logic [1:0] AluOpRFunct = 2'b10;
    localparam logic [1:0] AluOpIFunct = 2'b11;

    localparam logic [1:0] SrcARs1  = 2'b00;
    localparam logic [1:0] SrcAPc   = 2'b01;
    localparam logic [1:0] SrcAZero = 2'b10;

    localparam logic [1:0] PcSrcPlus4 = 2'b00;
    localparam logic [1:0] PcSrcImm   = 2'b01;
    localparam logic [1:0] PcSrcAlu   = 2'b10;

    localparam logic [1:0] WbAluOut = 2'b00;
    localparam logic [1:0] WbMem    = 2'b01;
    localparam logic [1:0] WbPc4    = 2'b10;

    typedef struct packed {
        logic       mem_req;
        logic       mem_read;
        logic       mem_write;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       branch;
        logic [1:0] pc_src;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       reg_write;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    function automatic opclass_t decode_opclass(input logic [6:0] op);
        opclass_t oc;
        case (op)
            OpcR:      oc = OcR;
            OpcImm:    oc = OcImm;
            OpcLoad:   oc = OcLoad;
            OpcStore:  oc = OcStore;
            OpcBranch: oc = OcBranch;
            OpcJal:    oc = OcJal;
            OpcJalr:   oc = OcJalr;
            OpcLui:    oc = OcLui;
            OpcAuipc:  oc = OcAuipc;
            default:   oc = OcNone;
        endcase
        return oc;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer: counts consecutive wait cycles of one memory request.
//   clk, rst   : clock, synchronous active-high reset
//   mem_req    : request outstanding this cycle
//   mem_ready  : memory completes the request this cycle
//   timeout    : wait count has reached MEM_TIMEOUT
// The count restarts whenever no request is pending or a request completes,
// so every new request begins at zero.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic mem_req,
    input  logic mem_ready,
    output logic timeout
);

    localparam int unsigned CntW = (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CntW'(MEM_TIMEOUT));

    always_comb begin
        cnt_d = cnt_q;
        if (!mem_req || mem_ready) begin
            cnt_d = '0;
        end else if (!timeout) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// multicycle_control_fsm: FETCH/DECODE/EXEC/MEM/WB sequencer for a
// multi-cycle RV32I datapath with a req/ready shared memory.
//   clk, rst        : clock, synchronous active-high reset
//   opcode          : instr[6:0] from the IR (valid from DECODE onward)
//   mem_ready       : memory accepts/completes the current request
//   mem_req         : memory request, held until mem_ready
//   MemRead/MemWrite: read (fetch/load) / write (store) request
//   IorD            : 0 = PC address, 1 = ALUOut address
//   IRWrite, PCWrite, Branch, PCSrc, ALUSrcA, ALUSrcB, ALUOp, WBSel,
//   RegWrite        : datapath controls
//   instr_done      : one-cycle retirement pulse
//   illegal         : unknown opcode flag (sticky in TRAP)
//   bus_err         : memory timeout flag
// Optional feature: define MEM_TIMEOUT_EN to add the memory wait timeout
// (sticky bus_err and TRAP after MEM_TIMEOUT wait cycles). Without it the
// FSM waits indefinitely and bus_err is tied 0.
module multicycle_control_fsm
    import ctrl_pkg::*;
#(
    parameter int unsigned HALT_ON_ILLEGAL = 1,
    parameter int unsigned MEM_TIMEOUT     = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opcode,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IorD,
    output logic       IRWrite,
    output logic       PCWrite,
    output logic       Branch,
    output logic [1:0] PCSrc,
    output logic [1:0] ALUSrcA,
    output logic       ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] WBSel,
    output logic       RegWrite,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_err
);

    state_t   state_q, state_d;
    opclass_t opclass_q, opclass_d;
    opclass_t dec_class;
    ctrl_t    ctrl_c, ctrl_o;
    logic     timeout;
    logic     set_bus_err;

    assign dec_class = decode_opclass(opcode);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StFetch;
            opclass_q <= OcNone;
        end else begin
            state_q   <= state_d;
            opclass_q <= opclass_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        opclass_d   = opclass_q;
        ctrl_c      = '0;
        set_bus_err = 1'b0;

        unique case (state_q)
            StFetch: begin
                ctrl_c.mem_req  = 1'b1;
                ctrl_c.mem_read = 1'b1;
                if (mem_ready) begin
                    ctrl_c.ir_write = 1'b1;
                    ctrl_c.pc_write = 1'b1;
                    ctrl_c.pc_src   = PcSrcPlus4;
                    state_d         = StDecode;
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = StTrap;
                end
            end

            StDecode: begin
                opclass_d = dec_class;
                if (dec_class == OcNone) begin
                    ctrl_c.illegal = 1'b1;
                    state_d        = (HALT_ON_ILLEGAL != 0) ? StTrap : StFetch;
                end else begin
                    state_d = StExec;
                end
            end

            StExec: begin
                unique case (opclass_q)
                    OcR: begin
                        ctrl_c.alu_src_a = SrcARs1;
                        ctrl_c.alu_op    = AluOpRFunct;
                        state_d          = StWb;
                    end
                    OcImm: begin
                        ctrl_c.alu_src_b = 1'b1;
                        ctrl_c.alu_op    = AluOpIFunct;
                        state_d          = StWb;
                    end
                    OcLoad, OcStore: begin
                        ctrl_c.alu_src_b = 1'b1;
                        ctrl_c.alu_op    = AluOpAdd;
                        state_d          = StMem;
                    end
                    OcBranch: begin
                        ctrl_c.alu_op     = AluOpBranch;
                        ctrl_c.branch     = 1'b1;
                        ctrl_c.pc_src     = PcSrcImm;
                        ctrl_c.instr_done = 1'b1;
                        state_d           = StFetch;
                    end
                    OcJal: begin
                        ctrl_c.pc_write   = 1'b1;
                        ctrl_c.pc_src     = PcSrcImm;
                        ctrl_c.reg_write  = 1'b1;
                        ctrl_c.wb_sel     = WbPc4;
                        ctrl_c.instr_done = 1'b1;
                        state_d           = StFetch;
                    end
                    OcJalr: begin
                        // Target LSB clearing is done in the datapath.
                        ctrl_c.alu_src_b  = 1'b1;
                        ctrl_c.alu_op     = AluOpAdd;
                        ctrl_c.pc_write   = 1'b1;
                        ctrl_c.pc_src     = PcSrcAlu;
                        ctrl_c.reg_write  = 1'b1;
                        ctrl_c.wb_sel     = WbPc4;
                        ctrl_c.instr_done = 1'b1;
                        state_d           = StFetch;
                    end
                    OcLui: begin
                        ctrl_c.alu_src_a = SrcAZero;
                        ctrl_c.alu_src_b = 1'b1;
                        state_d          = StWb;
                    end
                    OcAuipc: begin
                        ctrl_c.alu_src_a = SrcAPc;
                        ctrl_c.alu_src_b = 1'b1;
                        state_d          = StWb;
                    end
                    default: state_d = StFetch;
                endcase
            end

            StMem: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.iord      = 1'b1;
                ctrl_c.mem_read  = (opclass_q == OcLoad);
                ctrl_c.mem_write = (opclass_q == OcStore);
                if (mem_ready) begin
                    if (opclass_q == OcLoad) begin
                        state_d = StWb;
                    end else begin
                        ctrl_c.instr_done = 1'b1;
                        state_d           = StFetch;
                    end
                end else if (timeout) begin
                    set_bus_err = 1'b1;
                    state_d     = StTrap;
                end
            end

            StWb: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.wb_sel     = (opclass_q == OcLoad) ? WbMem : WbAluOut;
                ctrl_c.instr_done = 1'b1;
                state_d           = StFetch;
            end

            StTrap: begin
                ctrl_c.illegal = 1'b1;
            end

            default: state_d = StFetch;
        endcase
    end

    // Everything is forced low while reset is held, regardless of state.
    assign ctrl_o = rst ? '0 : ctrl_c;

    assign mem_req    = ctrl_o.mem_req;
    assign MemRead    = ctrl_o.mem_read;
    assign MemWrite   = ctrl_o.mem_write;
    assign IorD       = ctrl_o.iord;
    assign IRWrite    = ctrl_o.ir_write;
    assign PCWrite    = ctrl_o.pc_write;
    assign Branch     = ctrl_o.branch;
    assign PCSrc      = ctrl_o.pc_src;
    assign ALUSrcA    = ctrl_o.alu_src_a;
    assign ALUSrcB    = ctrl_o.alu_src_b;
    assign ALUOp      = ctrl_o.alu_op;
    assign WBSel      = ctrl_o.wb_sel;
    assign RegWrite   = ctrl_o.reg_write;
    assign instr_done = ctrl_o.instr_done;
    assign illegal    = ctrl_o.illegal;

`ifdef MEM_TIMEOUT_EN
    logic bus_err_q;

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_mem_wait_timer (
        .clk      (clk),
        .rst      (rst),
        .mem_req  (ctrl_c.mem_req),
        .mem_ready(mem_ready),
        .timeout  (timeout)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_err_q <= 1'b0;
        end else if (set_bus_err) begin
            bus_err_q <= 1'b1;
        end
    end

    assign bus_err = bus_err_q & ~rst;
`else
    logic unused_cfg;

    assign timeout    = 1'b0;
    assign bus_err    = 1'b0;
    assign unused_cfg = ^{MEM_TIMEOUT, set_bus_err};
`endif

endmodule
